// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch timekeeping and run/pause/adjust controller
// Button debounce counters are built only when DEBOUNCE_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int ADJ_DIV    = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       adjust,
  output logic       adj_sel,
  output logic       paused
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ADJ_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);

  if (TICK_DIV < 2 || ADJ_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_param
    $error("stopwatch_ctrl: TICK_DIV/ADJ_DIV must be >= 2 and DEB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_PAUSE, S_RUN, S_ADJUST} state_t;
  state_t state_q, state_d;

  // Bit order of the synchronizer: {sw_sel, sw_adj, btn_reset, btn_pause}
  logic [3:0]    sync1_q, sync2_q;
  logic [1:0]    btn_lvl;
  logic [1:0]    btn_prev_q;
  logic          pause_press, reset_press;
  logic          sw_adj_s, sw_sel_s;
  logic          state_change, tick, adj_inc;
  logic [TW-1:0] tick_cnt_q;
  logic [AW-1:0] adj_cnt_q;
  logic [5:0]    min_q, sec_q;
  logic          adjust_q, adj_sel_q, paused_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_sel, sw_adj, btn_reset, btn_pause};
      sync2_q <= sync1_q;
    end
  end

  assign sw_adj_s = sync2_q[2];
  assign sw_sel_s = sync2_q[3];

`ifdef DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt_q [2];
  logic [1:0]    deb_q;

  // The level follows the input only after DEB_CYCLES straight cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign btn_lvl = deb_q;
`else
  assign btn_lvl = sync2_q[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_prev_q <= '0;
    else        btn_prev_q <= btn_lvl;
  end

  assign pause_press = btn_lvl[0] & ~btn_prev_q[0];
  assign reset_press = btn_lvl[1] & ~btn_prev_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PAUSE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sw_adj_s) begin
      state_d = S_ADJUST;
    end else begin
      case (state_q)
        S_ADJUST: state_d = S_PAUSE;
        S_PAUSE:  if (pause_press) state_d = S_RUN;
        S_RUN:    if (pause_press) state_d = S_PAUSE;
        default:  state_d = S_PAUSE;
      endcase
    end
  end

  assign state_change = (state_d != state_q);
  assign tick         = (state_q == S_RUN)    && (tick_cnt_q == TICK_LAST);
  assign adj_inc      = (state_q == S_ADJUST) && (adj_cnt_q == ADJ_LAST);

  // Dividers restart from zero on any state change so the first step is a full period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      adj_cnt_q  <= '0;
    end else begin
      if (reset_press || state_change || state_q != S_RUN || tick) tick_cnt_q <= '0;
      else                                                         tick_cnt_q <= tick_cnt_q + 1'b1;
      if (reset_press || state_change || state_q != S_ADJUST || adj_inc) adj_cnt_q <= '0;
      else                                                               adj_cnt_q <= adj_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (reset_press) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_q <= '0;
        min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end else begin
        sec_q <= sec_q + 6'd1;
      end
    end else if (adj_inc) begin
      if (sw_sel_s) sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      else          min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adjust_q  <= 1'b0;
      adj_sel_q <= 1'b0;
      paused_q  <= 1'b1;
    end else begin
      adjust_q  <= (state_d == S_ADJUST);
      adj_sel_q <= sw_sel_s;
      paused_q  <= (state_d == S_PAUSE);
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign adjust  = adjust_q;
  assign adj_sel = adj_sel_q;
  assign paused  = paused_q;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Timekeeping and mode controller for the stopwatch. It produces the minute and second values plus the adjust flag that the seven-segment display driver renders. It conditions the pause and reset push-buttons and the adjust and select switches, then sequences a run/pause/adjust state machine. It drives the 1 Hz count and the faster adjust-mode increments, both derived from the single system clock.

## Interface
- TICK_DIV, 100_000_000: clk cycles per 1 Hz count tick (≥2)
- ADJ_DIV, 50_000_000: clk cycles per adjust increment (2 Hz at 100 MHz, ≥2)
- DEB_CYCLES, 1_000_000: consecutive stable cycles required by the debouncer (≥1; used only with DEBOUNCE_EN)
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_pause  in  1  raw push-button; each press toggles run/pause
- btn_reset  in  1  raw push-button; each press clears time to 00:00
- sw_adj  in  1  raw switch; high selects adjust mode
- sw_sel  in  1  raw switch; in adjust: 0 = adjust minutes, 1 = adjust seconds
- min  out  6  minutes, 0..59
- sec  out  6  seconds, 0..59
- adjust  out  1  high while in ADJUST; feeds the display's blink input
- adj_sel  out  1  synchronized sw_sel, registered
- paused  out  1  high in PAUSE state

## Operation
- Input conditioning: every raw input passes through a 2-flop synchronizer.
  - Buttons then pass through the optional debouncer (see Configuration), then a rising-edge detector giving a 1-cycle press pulse.
  - Switches are used as synchronized levels.
- States: PAUSE (reset state), RUN, ADJUST. Transitions, in priority order:
  - any state, sync sw_adj=1 -> ADJUST
  - ADJUST, sync sw_adj=0 -> PAUSE
  - PAUSE, pause press -> RUN
  - RUN, pause press -> PAUSE
  - pause press in ADJUST: ignored
- RUN: the tick divider counts 0..TICK_DIV-1. On the edge where it equals TICK_DIV-1, it returns to 0 and time advances.
  - sec 59 -> 0 with min+1.
  - min 59 with sec 59 -> 00:00.
- ADJUST: the adjust divider counts 0..ADJ_DIV-1. On terminal count, the selected field increments.
  - sw_sel=0: min +1, wrapping 59 -> 0; sec unchanged.
  - sw_sel=1: sec +1, wrapping 59 -> 0; no carry into min.
- PAUSE: min/sec hold.
- Reset press, any state: min=sec=0 and both dividers cleared; state unchanged.
  - Same cycle as a tick or adjust increment: reset wins (result 00:00).
  - Same cycle as a pause press: both take effect (clear + toggle).
- Both dividers clear to 0 on every state change. They hold at 0 while their state is not active.
- Divider widths are $clog2 of the respective parameter. min/sec are never outside 0..59.

## Timing
- rst_n low, asynchronously: min=0, sec=0, adjust=0, adj_sel=0, paused=1, state PAUSE; all synchronizer, debounce, edge and divider registers 0. Release is synchronous to the next clk edge.
- Button latency, without DEBOUNCE_EN: raw high sampled at edge 1; the action is registered at edge 3.
- Button latency, with DEBOUNCE_EN: the action is registered at edge 3+DEB_CYCLES.
- Switch latency: an sw_adj/sw_sel change sampled at edge 1 affects state/adj_sel at edge 3.
- First RUN increment: TICK_DIV edges after the edge that entered RUN; subsequent increments every TICK_DIV edges.
- First ADJUST increment: ADJ_DIV edges after entering ADJUST.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- DEBOUNCE_EN defined: each synchronized button feeds a counter-based debouncer. The debounced level changes only after DEB_CYCLES consecutive cycles at the new value. Any bounce restarts the count.
- DEBOUNCE_EN undefined: the synchronized level feeds the edge detector directly. DEB_CYCLES is unused and no debounce counters are built.

## Test plan
Parameters: TICK_DIV=4, ADJ_DIV=2, DEB_CYCLES=3.
- Reset: assert rst_n=0 mid-RUN at 00:05 -> immediately min=0, sec=0, paused=1, adjust=0. After release, no counting until a pause press.
- Run/wrap: pause press, then 240 cycles -> 01:00 and paused=0. Second pause press -> time holds for 20 cycles.
- Adjust: sw_adj=1, sw_sel=0 -> adjust=1 at edge 3; min +1 every 2 cycles; 59 -> 0; sec unchanged. sw_sel=1 from sec=59 -> 0 with min unchanged. sw_adj=0 -> PAUSE, paused=1.
- Full wrap: adjust to 59:59, run -> 00:00 after 4 cycles.
- Collisions: reset press coincident with the RUN terminal tick at 00:09 -> 00:00. Reset + pause press same cycle in PAUSE -> 00:00 and RUN.
- Debounce: a 2-cycle btn_pause glitch is ignored with DEBOUNCE_EN and toggles state without it. A 6-cycle press toggles exactly once in both builds.
